// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Streams program bytes from a valid/ready source into a byte-wide RAM over
// the shared system bus. While a load session runs, the CPU controller is
// halted so the loader is the only bus driver. Each accepted byte is written
// to consecutive addresses starting at 0. The session ends after a byte
// flagged in_last, or after the last RAM location has been written.
//
// Optional feature (build macro MEM_LOADER_CHECKSUM_EN):
//   Adds output checksum[7:0], the mod-256 sum of the bytes written in the
//   current or last session.
//
// Parameters
//   ADDR_W      RAM address width
//   DEPTH       number of RAM bytes (2**ADDR_W)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   load_start  one-cycle request to begin a session (ignored unless idle)
//   in_valid    source presents a byte on in_data
//   in_data     program byte from source
//   in_last     marks the accepted byte as the final one
//   in_ready    loader accepts a byte this cycle
//   mar_addr    MAR address, passed through to addr while idle
//   addr        RAM address
//   bus         shared bus, driven only during a RAM write, else high-Z
//   ram_write   RAM write strobe
//   cpu_halt    stalls the CPU controller while a session runs
//   busy        session in progress
//   done        one-cycle pulse at session end
//   count       bytes written in the current/last session
//   checksum    (optional) running byte sum of the session
// ---------------------------------------------------------------------------
module mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mar_addr,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        bus,
  output logic              ram_write,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        held_data_q, held_data_d;
  logic              held_last_q, held_last_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_write_q, ram_write_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]        checksum_q, checksum_d;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    held_data_d = held_data_q;
    held_last_d = held_last_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_ACCEPT;
          ptr_d   = '0;
          count_d = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          held_data_d = in_data;
          held_last_d = in_last;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + CNT_ONE;
`ifdef MEM_LOADER_CHECKSUM_EN
        checksum_d = checksum_q + held_data_q;
`endif
        // Stop at the top of RAM even without in_last so ptr never wraps.
        if (held_last_q || (ptr_q == LAST_PTR)) begin
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == S_ACCEPT);
    ram_write_d = (state_d == S_WRITE);
    halt_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // Control state: asynchronous reset returns everything to a quiet idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      ram_write_q <= 1'b0;
      halt_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      ram_write_q <= ram_write_d;
      halt_q      <= halt_d;
      done_q      <= done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Holding registers carry data only; they are never driven onto the bus
  // unless ram_write_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    held_data_q <= held_data_d;
    held_last_q <= held_last_d;
  end

  // While idle the MAR owns the RAM address; during a session the pointer does.
  assign addr      = (state_q == S_IDLE) ? mar_addr : ptr_q;
  assign bus       = ram_write_q ? held_data_q : 8'hzz;
  assign in_ready  = in_ready_q;
  assign ram_write = ram_write_q;
  assign cpu_halt  = halt_q;
  assign busy      = halt_q;
  assign done      = done_q;
  assign count     = count_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule
